maxnet_ctrl: RTL and testbench
==============================

Name: maxnet_ctrl

Overview:
- FSM controller that sequences the 4-neuron Maxnet iteration datapath.
- Loads the initial activations, then repeatedly lets the datapath settle and samples the winner decoder's done/idx outputs. It commands another inhibition update until exactly one neuron remains nonzero or an iteration limit is reached.
- Returns the winner index to the host through a valid/ack handshake.

Parameters:
- MAX_ITER, 31, maximum number of update cycles before timeout (1..2^ITER_W-1).
- ITER_W, 5, width of the iteration counter.
- SETTLE_CYCLES, 2, clock cycles to wait after any register load before sampling done_in (>=1); covers combinational gate delays.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  host request to begin a run; sampled only in IDLE.
- done_in  in  1  winner decoder "exactly one nonzero" flag.
- idx_in  in  2  winner decoder index (0=A1 .. 3=A4).
- ld_init  out  1  one-cycle strobe: datapath registers load the initial activations.
- ld_upd  out  1  one-cycle strobe: datapath registers load the inhibited values.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  result available; held until result_ack.
- result_ack  in  1  host consumes the result.
- winner  out  2  registered winner index.
- timeout  out  1  registered; run ended without a single winner.
- iter_count  out  ITER_W  number of updates performed in the last run (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ld_init=ld_upd=busy=result_valid=timeout=0.
  - winner=0, iter_count=0, iteration counter=0, settle counter=0.
- All outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> LOAD.
  - winner and timeout hold their last values.
- LOAD (1 cycle):
  - ld_init=1.
  - Iteration counter cleared to 0; timeout cleared to 0.
  - Next state: SETTLE.
- SETTLE (exactly SETTLE_CYCLES cycles):
  - Settle counter counts 0..SETTLE_CYCLES-1, then the FSM moves to CHECK.
  - Settle counter is cleared on entry.
- CHECK (1 cycle), evaluated in this priority:
  - done_in=1: winner<=idx_in, timeout<=0 -> FINISH.
  - else iteration counter==MAX_ITER: timeout<=1, winner<=0 -> FINISH.
  - else -> UPDATE.
- UPDATE (1 cycle):
  - ld_upd=1.
  - Iteration counter +1; it cannot wrap because MAX_ITER<2^ITER_W.
  - Next state: SETTLE.
- FINISH:
  - result_valid=1; winner and timeout are stable.
  - result_ack=1 -> IDLE; result_valid drops on the same edge.
- Latency, measured from the edge that samples start:
  - result_valid rises after 2+SETTLE_CYCLES cycles if no update is needed.
  - Each update adds 2+SETTLE_CYCLES cycles.
  - With defaults: 4 + 4*N cycles for N updates.
- Boundary conditions:
  - start outside IDLE is ignored.
  - start and result_ack both high in FINISH: return to IDLE; start is not captured and must be held or reasserted.
  - result_ack outside FINISH is ignored.
  - All activations zero: done_in never rises -> timeout after MAX_ITER updates.
  - ld_init and ld_upd are never high simultaneously.
  - rst_n low mid-run: immediate return to IDLE with reset values; no strobe is issued.
  - done_in and idx_in are sampled only in CHECK; glitches in other states have no effect.

Optional Feature:
- Macro: MAXNET_CTRL_ITER_STAT_EN.
- Defined: on entry to FINISH, iter_count latches the iteration counter. It holds that value until the next FINISH or reset.
- Undefined: iter_count is tied to 0 and no latch register is synthesized. FSM behaviour is otherwise identical.

Test Plan:
- Immediate winner:
  - Stimulus: reset, start pulse, done_in=1, idx_in=2 throughout.
  - Response: ld_init one cycle after start; result_valid after 4 cycles; winner=2, timeout=0, no ld_upd strobe; iter_count=0 with macro.
- Three updates:
  - Stimulus: done_in=0 until after the third ld_upd, then done_in=1, idx_in=3.
  - Response: exactly 3 ld_upd strobes each spaced 4 cycles apart; result_valid at cycle 16; winner=3; iter_count=3 with macro, 0 without.
- Timeout:
  - Stimulus: done_in held 0, MAX_ITER=31.
  - Response: 31 ld_upd strobes; timeout=1, winner=0; result_valid at cycle 4+4*31=128.
- Handshake:
  - Stimulus: hold result_ack=0 for 10 cycles in FINISH, pulse start during that time, then assert result_ack and start together.
  - Response: result_valid stays high and outputs are stable; start is ignored; FSM returns to IDLE with busy=0 and no new run.
- Async reset mid-run:
  - Stimulus: drop rst_n during SETTLE of the second iteration, between clock edges.
  - Response: busy, ld_* and result_valid go 0 immediately; after release, a start begins a clean run with ld_init.
- Glitch immunity:
  - Stimulus: toggle done_in=1 only during SETTLE cycles, keeping it 0 in CHECK, for 2 iterations.
  - Response: updates continue; no early result_valid.

Source files
------------

// File: rtl/maxnet_ctrl.sv
// Sequencing FSM for the 4-neuron Maxnet datapath: load, settle, check, update, report.
// Optional MAXNET_CTRL_ITER_STAT_EN latches the update count of each run on iter_count.
module maxnet_ctrl #(
  parameter int MAX_ITER      = 31,
  parameter int ITER_W        = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done_in,
  input  logic [1:0]        idx_in,
  output logic              ld_init,
  output logic              ld_upd,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ack,
  output logic [1:0]        winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CHECK,
    UPDATE,
    FINISH
  } state_t;

  state_t            state;
  logic [ITER_W-1:0] iter_cnt;
  logic [SET_W-1:0]  settle_cnt;

  // Strobes default low each cycle, so a load pulse lasts exactly one state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ld_init      <= 1'b0;
      ld_upd       <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      winner       <= 2'd0;
      iter_cnt     <= '0;
      settle_cnt   <= '0;
    end else begin
      ld_init <= 1'b0;
      ld_upd  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            ld_init <= 1'b1;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          iter_cnt   <= '0;
          timeout    <= 1'b0;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (done_in) begin
            winner       <= idx_in;
            timeout      <= 1'b0;
            result_valid <= 1'b1;
            state        <= FINISH;
          end else if (iter_cnt == ITER_W'(MAX_ITER)) begin
            winner       <= 2'd0;
            timeout      <= 1'b1;
            result_valid <= 1'b1;
            state        <= FINISH;
          end else begin
            ld_upd <= 1'b1;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          iter_cnt   <= iter_cnt + 1'b1;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        FINISH: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

`ifdef MAXNET_CTRL_ITER_STAT_EN
  logic finish_entry;

  assign finish_entry = (state == CHECK) && (done_in || (iter_cnt == ITER_W'(MAX_ITER)));

  // Captures the update count on the same edge the FSM enters FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_count <= '0;
    end else if (finish_entry) begin
      iter_count <= iter_cnt;
    end
  end
`else
  assign iter_count = '0;
`endif

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed self-checking bench for maxnet_ctrl with hand-computed latencies and results.
module tb_maxnet_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       done_in;
  logic [1:0] idx_in;
  logic       ld_init;
  logic       ld_upd;
  logic       busy;
  logic       result_valid;
  logic       result_ack;
  logic [1:0] winner;
  logic       timeout;
  logic [4:0] iter_count;

  int checks   = 0;
  int failures = 0;

  maxnet_ctrl #(
    .MAX_ITER     (31),
    .ITER_W       (5),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done_in     (done_in),
    .idx_in      (idx_in),
    .ld_init     (ld_init),
    .ld_upd      (ld_upd),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .winner      (winner),
    .timeout     (timeout),
    .iter_count  (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches a run; done_in rises once done_after updates have been seen.
  // Glitch mode pulses done_in during SETTLE of the first two iterations only.
  task automatic applyStimulus(input int done_after, input bit glitch, input logic [1:0] idx,
                               input int budget, output int cyc, output int upd, output int bad);
    int last_upd;
    cyc      = -1;
    upd      = 0;
    bad      = 0;
    last_upd = 0;
    start    = 1'b1;
    done_in  = (done_after == 0);
    idx_in   = idx;
    for (int k = 0; k <= budget; k++) begin
      tick();
      start = 1'b0;
      if (ld_init && ld_upd) bad++;
      if (ld_init != (k == 0)) bad++;
      if (!busy) bad++;
      if (ld_upd) begin
        upd++;
        if (k - last_upd != 4) bad++;
        last_upd = k;
      end
      if (result_valid) begin
        cyc = k;
        break;
      end
      done_in = (upd >= done_after);
      idx_in  = idx;
      if (glitch && k < 8 && (k % 4 == 1 || k % 4 == 2)) begin
        done_in = 1'b1;
        idx_in  = ~idx;
      end
    end
    done_in = 1'b0;
  endtask

  task automatic ackResult(input string tag);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    checkOutput({tag, "_valid_drop"}, result_valid, 0);
    checkOutput({tag, "_busy_drop"}, busy, 0);
  endtask

  int cyc;
  int upd;
  int bad;
  int exp_iter3;
  int exp_iter31;

  initial begin
`ifdef MAXNET_CTRL_ITER_STAT_EN
    exp_iter3  = 3;
    exp_iter31 = 31;
`else
    exp_iter3  = 0;
    exp_iter31 = 0;
`endif
    rst_n      = 1'b0;
    start      = 1'b0;
    done_in    = 1'b0;
    idx_in     = 2'd0;
    result_ack = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_strobes", {30'd0, ld_init, ld_upd}, 0);
    checkOutput("rst_valid", result_valid, 0);
    checkOutput("rst_winner", winner, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_iter", iter_count, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_busy", busy, 0);

    $display("[TB] immediate winner");
    applyStimulus(0, 1'b0, 2'd2, 40, cyc, upd, bad);
    checkOutput("imm_latency", cyc, 4);
    checkOutput("imm_updates", upd, 0);
    checkOutput("imm_protocol", bad, 0);
    checkOutput("imm_winner", winner, 2);
    checkOutput("imm_timeout", timeout, 0);
    checkOutput("imm_iter", iter_count, 0);
    ackResult("imm");
    checkOutput("idle_winner_hold", winner, 2);

    $display("[TB] three updates");
    applyStimulus(3, 1'b0, 2'd3, 60, cyc, upd, bad);
    checkOutput("upd3_latency", cyc, 16);
    checkOutput("upd3_updates", upd, 3);
    checkOutput("upd3_protocol", bad, 0);
    checkOutput("upd3_winner", winner, 3);
    checkOutput("upd3_timeout", timeout, 0);
    checkOutput("upd3_iter", iter_count, exp_iter3);
    ackResult("upd3");

    $display("[TB] timeout");
    applyStimulus(1000, 1'b0, 2'd1, 200, cyc, upd, bad);
    checkOutput("to_latency", cyc, 128);
    checkOutput("to_updates", upd, 31);
    checkOutput("to_protocol", bad, 0);
    checkOutput("to_winner", winner, 0);
    checkOutput("to_timeout", timeout, 1);
    checkOutput("to_iter", iter_count, exp_iter31);
    ackResult("to");
    checkOutput("idle_timeout_hold", timeout, 1);

    $display("[TB] glitch immunity");
    applyStimulus(3, 1'b1, 2'd1, 60, cyc, upd, bad);
    checkOutput("gl_latency", cyc, 16);
    checkOutput("gl_updates", upd, 3);
    checkOutput("gl_protocol", bad, 0);
    checkOutput("gl_winner", winner, 1);
    checkOutput("gl_timeout", timeout, 0);

    $display("[TB] handshake");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      if (!result_valid || winner != 2'd1 || timeout || !busy || ld_init || ld_upd) bad++;
    end
    checkOutput("hs_hold", bad, 0);
    result_ack = 1'b1;
    start      = 1'b1;
    tick();
    result_ack = 1'b0;
    start      = 1'b0;
    checkOutput("hs_valid_drop", result_valid, 0);
    checkOutput("hs_busy_drop", busy, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy || ld_init || result_valid) bad++;
    end
    checkOutput("hs_no_new_run", bad, 0);

    $display("[TB] async reset mid-run");
    start   = 1'b1;
    done_in = 1'b0;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checkOutput("mr_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_strobes", {30'd0, ld_init, ld_upd}, 0);
    checkOutput("mr_valid", result_valid, 0);
    checkOutput("mr_winner", winner, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("mr_idle", busy, 0);
    applyStimulus(0, 1'b0, 2'd3, 40, cyc, upd, bad);
    checkOutput("mr_rerun_latency", cyc, 4);
    checkOutput("mr_rerun_protocol", bad, 0);
    checkOutput("mr_rerun_winner", winner, 3);
    ackResult("mr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
